// File: rtl/mosfet_seq_ctrl_pkg.sv
// Shared widths, state encoding and beat record for the MOSFET sequencing controller.
// Consumed by mosfet_seq_ctrl_if, mosfet_param_buf and mosfet_seq_ctrl.
package mosfet_ctrl_pkg;

    localparam int NUM_FET = 6;
    localparam int FIELD_W = 3;
    localparam int MODE_W  = 2;
    localparam int OUT_W   = 8;
    localparam int CNT_W   = 3;
    localparam int BUS_W   = NUM_FET * FIELD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // One transistor as carried by a single beat.
    typedef struct packed {
        logic [FIELD_W-1:0] w;
        logic [FIELD_W-1:0] vgs;
        logic [FIELD_W-1:0] vds;
    } fet_t;

endpackage

// File: rtl/mosfet_seq_ctrl_if.sv
// Serial job bus between upstream logic (master) and mosfet_seq_ctrl (slave).
interface mosfet_seq_ctrl_if;
    import mosfet_ctrl_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [MODE_W-1:0]  mode;
    logic [FIELD_W-1:0] W;
    logic [FIELD_W-1:0] V_GS;
    logic [FIELD_W-1:0] V_DS;
    logic               out_valid;
    logic [OUT_W-1:0]   out_n;
    logic               err;

    modport master (
        output in_valid, mode, W, V_GS, V_DS,
        input  in_ready, out_valid, out_n, err
    );

    modport slave (
        input  in_valid, mode, W, V_GS, V_DS,
        output in_ready, out_valid, out_n, err
    );

endinterface

// File: rtl/mosfet_param_buf.sv
// Six-entry transistor parameter register file plus job mode register.
// Outputs are the packed calculator operands; entry k sits at bits [3k+2:3k].
module mosfet_param_buf
    import mosfet_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [CNT_W-1:0]   wr_idx,
    input  fet_t               wr_data,
    input  logic               mode_wr_en,
    input  logic [MODE_W-1:0]  mode_in,
    output logic [MODE_W-1:0]  calc_mode,
    output logic [BUS_W-1:0]   calc_w,
    output logic [BUS_W-1:0]   calc_vgs,
    output logic [BUS_W-1:0]   calc_vds
);

    fet_t entry [NUM_FET];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FET; i++) begin
                entry[i] <= '0;
            end
            calc_mode <= '0;
        end else begin
            if (wr_en && (wr_idx < CNT_W'(NUM_FET))) begin
                entry[wr_idx] <= wr_data;
            end
            if (mode_wr_en) begin
                calc_mode <= mode_in;
            end
        end
    end

    always_comb begin
        calc_w   = '0;
        calc_vgs = '0;
        calc_vds = '0;
        for (int k = 0; k < NUM_FET; k++) begin
            calc_w[k*FIELD_W +: FIELD_W]   = entry[k].w;
            calc_vgs[k*FIELD_W +: FIELD_W] = entry[k].vgs;
            calc_vds[k*FIELD_W +: FIELD_W] = entry[k].vds;
        end
    end

endmodule

// File: rtl/mosfet_seq_ctrl.sv
// Serial job front end for the combinational MOSFET calculator: six beats in, one strobed result out.
// Optional inter-beat timeout abort is compiled in with MOSFET_SEQ_CTRL_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | waiting for beat 0; latches mode
//   LOAD  | collecting beats 1..5; gaps allowed
//   WAIT  | operands frozen, settle down-counter running
//   DONE  | one cycle: drop result strobe, reopen in_ready
module mosfet_seq_ctrl
    import mosfet_ctrl_pkg::*;
#(
    parameter int CALC_CYC = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    mosfet_seq_ctrl_if.slave    bus,
    output logic [MODE_W-1:0]   calc_mode,
    output logic [BUS_W-1:0]    calc_w,
    output logic [BUS_W-1:0]    calc_vgs,
    output logic [BUS_W-1:0]    calc_vds,
    input  logic [OUT_W-1:0]    calc_out_n
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_LOAD = LOAD;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_FET - 1);
    localparam logic [2:0]       SETTLE_LOAD = 3'(CALC_CYC - 1);

    if (CALC_CYC < 1 || CALC_CYC > 7 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_cfg_check
        $error("mosfet_seq_ctrl: CALC_CYC must be 1..7 and TIMEOUT 1..255");
    end

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        settle;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [OUT_W-1:0]  out_n_q;
    logic              err_q;
    logic              abort;
    logic              accept;
    fet_t              beat;

    assign accept = bus.in_valid && in_ready_q && !abort;
    assign beat   = {bus.W, bus.V_GS, bus.V_DS};

    mosfet_param_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (accept),
        .wr_idx     ((state == S_IDLE) ? '0 : cnt),
        .wr_data    (beat),
        .mode_wr_en (accept && (state == S_IDLE)),
        .mode_in    (bus.mode),
        .calc_mode  (calc_mode),
        .calc_w     (calc_w),
        .calc_vgs   (calc_vgs),
        .calc_vds   (calc_vds)
    );

`ifdef MOSFET_SEQ_CTRL_TIMEOUT_EN
    logic [7:0] gap_tmr;

    // Terminal count marks the abort cycle; any beat offered then is refused.
    assign abort = (state == S_LOAD) && (gap_tmr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_tmr <= 8'(TIMEOUT);
            err_q   <= 1'b0;
        end else begin
            err_q <= abort;
            if (accept || abort || (state != S_LOAD)) begin
                gap_tmr <= 8'(TIMEOUT);
            end else begin
                gap_tmr <= gap_tmr - 1'b1;
            end
        end
    end
`else
    assign abort = 1'b0;
    assign err_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            settle      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt   <= CNT_W'(1);
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (accept) begin
                        if (cnt == LAST_IDX) begin
                            cnt        <= '0;
                            settle     <= SETTLE_LOAD;
                            in_ready_q <= 1'b0;
                            state      <= S_WAIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // Operands have been stable for CALC_CYC edges when the counter hits zero.
                    if (settle == '0) begin
                        out_n_q     <= calc_out_n;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        settle <= settle - 1'b1;
                    end
                end
                S_DONE: begin
                    out_valid_q <= 1'b0;
                    out_n_q     <= '0;
                    in_ready_q  <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_n     = out_n_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mosfet_seq_ctrl.sv
// Scoreboard bench for mosfet_seq_ctrl: two instances (CALC_CYC=1 and 3) driven with directed jobs.
// Timeout scenario follows MOSFET_SEQ_CTRL_TIMEOUT_EN.
module tb_mosfet_seq_ctrl;

    typedef struct {
        logic [7:0]  n;
        logic [1:0]  m;
        logic [17:0] w;
        logic [17:0] g;
        logic [17:0] d;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   err_cnt [2];
    int   exp_err = 0;
    exp_t q [2][$];
    exp_t cexp [2];

    logic [1:0]  cm1, cm3;
    logic [17:0] cw1, cg1, cd1, cw3, cg3, cd3;
    logic [7:0]  co1, co3;

    mosfet_seq_ctrl_if b1 ();
    mosfet_seq_ctrl_if b3 ();

    mosfet_seq_ctrl #(.CALC_CYC(1), .TIMEOUT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .calc_mode(cm1),
        .calc_w(cw1), .calc_vgs(cg1), .calc_vds(cd1), .calc_out_n(co1)
    );

    mosfet_seq_ctrl #(.CALC_CYC(3), .TIMEOUT(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3), .calc_mode(cm3),
        .calc_w(cw3), .calc_vgs(cg3), .calc_vds(cd3), .calc_out_n(co3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Calculator stand-in: returns the job's result only when fed the exact expected operands.
    always_comb begin
        co1 = (cm1 == cexp[0].m && cw1 == cexp[0].w && cg1 == cexp[0].g && cd1 == cexp[0].d)
              ? cexp[0].n : 8'hEE;
        co3 = (cm3 == cexp[1].m && cw3 == cexp[1].w && cg3 == cexp[1].g && cd3 == cexp[1].d)
              ? cexp[1].n : 8'hEE;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic logic [8:0] beat_of(input int job, input int k);
        logic [2:0] w, g, d;
        case (job)
            0: begin w = 3'(k + 1); g = 3'(k);     d = 3'(7 - k); end
            1: begin w = 3'(7 - k); g = 3'(k + 2); d = 3'(k);     end
            default: begin w = 3'(k * 3); g = 3'd1; d = 3'(k ^ 5); end
        endcase
        return {w, g, d};
    endfunction

    function automatic exp_t exp_of(input int job, input logic [1:0] m);
        exp_t e;
        e.m = m;
        e.cyc = 0;
        case (job)
            0: begin
                e.w = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
                e.g = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
                e.d = {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
                e.n = 8'd93;
            end
            1: begin
                e.w = {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
                e.g = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
                e.d = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
                e.n = 8'd41;
            end
            default: begin
                e.w = {3'd7, 3'd4, 3'd1, 3'd6, 3'd3, 3'd0};
                e.g = {3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
                e.d = {3'd0, 3'd1, 3'd6, 3'd7, 3'd4, 3'd5};
                e.n = 8'd200;
            end
        endcase
        return e;
    endfunction

    task automatic mon(input int s, input logic ov, input logic [7:0] on, input logic [1:0] m,
                       input logic [17:0] w, input logic [17:0] g, input logic [17:0] d);
        exp_t e;
        string t;
        t = (s == 0) ? "c1" : "c3";
        if (ov) begin
            if (q[s].size() == 0) begin
                chk({t, " spurious out_valid, jobs pending"}, q[s].size(), 1);
            end else begin
                e = q[s].pop_front();
                chk({t, " out_n"}, on, e.n);
                chk({t, " calc_mode"}, m, e.m);
                chk({t, " calc_w"}, w, e.w);
                chk({t, " calc_vgs"}, g, e.g);
                chk({t, " calc_vds"}, d, e.d);
                chk({t, " out_valid cycle"}, cyc, e.cyc);
            end
        end else begin
            chk({t, " out_n while idle"}, on, 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, b1.out_valid, b1.out_n, cm1, cw1, cg1, cd1);
        mon(1, b3.out_valid, b3.out_n, cm3, cw3, cg3, cd3);
        if (b1.err) err_cnt[0]++;
        if (b3.err) err_cnt[1]++;
    end

    task automatic drive(input int s, input logic v, input logic [1:0] m, input logic [8:0] f);
        if (s == 0) begin
            b1.in_valid = v; b1.mode = m; {b1.W, b1.V_GS, b1.V_DS} = f;
        end else begin
            b3.in_valid = v; b3.mode = m; {b3.W, b3.V_GS, b3.V_DS} = f;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int s, input int job, input int k, input logic [1:0] m);
        drive(s, 1'b1, m, beat_of(job, k));
        tick(1);
    endtask

    task automatic idle(input int s, input int n);
        drive(s, 1'b0, 2'd0, 9'd0);
        tick(n);
    endtask

    // Six beats; mode m0 on beat 0, mr afterwards; optional gap after beat ga. Leaves in_valid high.
    task automatic run_job(input int s, input int job, input logic [1:0] m0, input logic [1:0] mr,
                           input int ga, input int gl, input int cc);
        exp_t e;
        e = exp_of(job, m0);
        cexp[s] = e;
        for (int k = 0; k < 6; k++) begin
            beat(s, job, k, (k == 0) ? m0 : mr);
            if (k == ga) idle(s, gl);
        end
        e.cyc = cyc + cc;
        q[s].push_back(e);
    endtask

    task automatic junk_then_job(input int s, input int cc, input int job, input logic [1:0] m);
        drive(s, 1'b1, 2'd0, 9'h1FF);
        tick(cc + 1);
        run_job(s, job, m, m, -1, 0, cc);
    endtask

    initial begin
        int e2, got;
        err_cnt[0] = 0;
        err_cnt[1] = 0;
        cexp[0] = exp_of(0, 2'd0);
        cexp[1] = exp_of(0, 2'd0);
        drive(0, 1'b0, 2'd0, 9'd0);
        drive(1, 1'b0, 2'd0, 9'd0);
        #1 rst_n = 1'b0;
        tick(3);
        chk("c1 reset in_ready", b1.in_ready, 1);
        chk("c3 reset in_ready", b3.in_ready, 1);
        chk("c1 reset out_valid", b1.out_valid, 0);
        chk("c1 reset err", b1.err, 0);
        chk("c1 reset calc_w", cw1, 0);
        #2 rst_n = 1'b1;
        tick(2);

        // Basic job on CALC_CYC=1.
        run_job(0, 0, 2'd1, 2'd1, -1, 0, 1);
        chk("c1 in_ready at E0", b1.in_ready, 0);
        idle(0, 1);
        chk("c1 in_ready at E0+1", b1.in_ready, 0);
        tick(1);
        chk("c1 in_ready at E0+2", b1.in_ready, 1);
        tick(2);

        // Gapped job on CALC_CYC=3; beats 1..5 carry mode 3.
        run_job(1, 0, 2'd1, 2'd3, 2, 2, 3);
        idle(1, 6);

        // Back-pressure: in_valid never drops across two jobs.
        run_job(0, 1, 2'd2, 2'd2, -1, 0, 1);
        junk_then_job(0, 1, 2, 2'd3);
        idle(0, 4);
        run_job(1, 1, 2'd2, 2'd2, -1, 0, 3);
        junk_then_job(1, 3, 2, 2'd3);
        idle(1, 6);

        // Reset after beat 3.
        for (int k = 0; k < 4; k++) beat(0, 1, k, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("c1 async rst in_ready", b1.in_ready, 1);
        chk("c1 async rst calc_mode", cm1, 0);
        chk("c1 async rst calc_w", cw1, 0);
        chk("c1 async rst calc_vgs", cg1, 0);
        chk("c1 async rst calc_vds", cd1, 0);
        chk("c1 async rst out_n", b1.out_n, 0);
        drive(0, 1'b0, 2'd0, 9'd0);
        tick(2);
        #2 rst_n = 1'b1;
        tick(1);
        run_job(0, 2, 2'd2, 2'd0, -1, 0, 1);
        idle(0, 4);

`ifdef MOSFET_SEQ_CTRL_TIMEOUT_EN
        for (int k = 0; k < 3; k++) beat(0, 0, k, 2'd1);
        e2 = cyc;
        drive(0, 1'b0, 2'd0, 9'd0);
        got = -1;
        for (int i = 0; i < 20 && got < 0; i++) begin
            tick(1);
            if (b1.err) got = cyc;
        end
        chk("c1 err pulse cycle", got, e2 + 5);
        exp_err = 1;
        run_job(0, 1, 2'd2, 2'd2, -1, 0, 1);
        idle(0, 4);
`else
        run_job(0, 0, 2'd1, 2'd1, 2, 100, 1);
        idle(0, 4);
        exp_err = 0;
`endif

        for (int i = 0; i < 50 && (q[0].size() != 0 || q[1].size() != 0); i++) tick(1);
        chk("c1 jobs outstanding", q[0].size(), 0);
        chk("c3 jobs outstanding", q[1].size(), 0);
        chk("c1 err cycles", err_cnt[0], exp_err);
        chk("c3 err cycles", err_cnt[1], 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
